led_wave_guess: RTL and testbench

Parametrised LED-wave count-guessing game engine, the successor of the fixed 16-LED mode-2 game. A bouncing bar of lit LEDs grows and shrinks once per tick. The player stops it with the go/stop button and tries to match a random target within a limited number of tries. The block sits beside the other game modes under the mode selector: `active` comes from the selector, `led` drives the LED bank, and `seg_data` feeds the shared 4-digit 7-segment decoder.

---
 rtl/led_game_pkg.sv | 32 +++
 rtl/led_wave_guess_lfsr16.sv | 22 ++
 rtl/led_wave_guess.sv | 180 ++++++++++++++++++
 tb/tb_led_wave_guess.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/led_game_pkg.sv
// Shared types and constants for the LED-wave guessing game: FSM states,
// 7-segment glyph codes, LFSR seed and a two-digit split helper.
package led_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SHOW,
        S_WIN,
        S_LOSE
    } state_e;

    localparam logic [4:0] C_BLANK = 5'd31;
    localparam logic [4:0] C_U     = 5'd15;
    localparam logic [4:0] C_P     = 5'd16;
    localparam logic [4:0] C_d     = 5'd19;
    localparam logic [4:0] C_n     = 5'd20;
    localparam logic [4:0] C_g     = 5'd9;
    localparam logic [4:0] C_o     = 5'd17;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // {tens glyph, units glyph} for a value below 64
    function automatic logic [9:0] dec2(input logic [5:0] v);
        logic [5:0] t;
        logic [5:0] u;
        t = v / 6'd10;
        u = v - t * 6'd10;
        return {t[4:0], u[4:0]};
    endfunction

endpackage

// File: rtl/led_wave_guess_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^15+x^13+x^4+1.
// Seeded non-zero on reset, so the all-zero lock-up state is never entered.
module lfsr16
    import led_game_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

endmodule

// File: rtl/led_wave_guess.sv
// LED-wave count-guessing game engine. Optional SHOW-state up/down hint
// is enabled by defining LED_WAVE_HINT_EN.
module led_wave_guess
    import led_game_pkg::*;
#(
    parameter int N_LED       = 16,
    parameter int TICK_CYCLES = 100_000_000,
    parameter int MAX_TRIES   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             btn_go_stop,
    output logic [N_LED-1:0] led,
    output logic [19:0]      seg_data,
    output logic [3:0]       tries_left,
    output logic             win,
    output logic             lose
);

    localparam int CW = $clog2(N_LED + 1);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [19:0] SEG_BLANK = {4{C_BLANK}};

    state_e           state_q;
    logic [CW-1:0]    c_q;
    logic             dir_q;
    logic [CW-1:0]    target_q;
    logic [3:0]       tries_q;
    logic [TW-1:0]    tick_q;
    logic             btn_prev_q;
    logic [N_LED-1:0] led_q;
    logic [19:0]      seg_q;
    logic             win_q;
    logic             lose_q;

    logic [15:0]      lfsr;
    logic             lfsr_unused;
    logic             btn_edge;
    logic             tick_hit;
    logic [CW-1:0]    target_d;
    logic [CW-1:0]    c_d;
    logic             dir_d;
    logic [N_LED-1:0] ones;
    logic [N_LED-1:0] wave;
    logic [9:0]       tgt_dec;
    logic [9:0]       c_dec;
    logic [9:0]       hint;
    logic [N_LED-1:0] led_d;
    logic [19:0]      seg_d;

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .lfsr_o (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:8];
    assign btn_edge    = btn_go_stop & ~btn_prev_q;
    assign tick_hit    = (tick_q == TW'(TICK_CYCLES - 1));
    // Scale the 8-bit random value onto 1..N_LED
    assign target_d    = CW'((32'(lfsr[7:0]) * N_LED) >> 8) + CW'(1);
    assign ones        = '1;
    assign wave        = ~(ones >> c_q);
    assign tgt_dec     = dec2(6'(target_q));
    assign c_dec       = dec2(6'(c_q));

    assign led        = led_q;
    assign seg_data   = seg_q;
    assign tries_left = tries_q;
    assign win        = win_q;
    assign lose       = lose_q;

    // Bounce at the ends: direction is decided by the value, not by dir_q
    always_comb begin
        c_d   = c_q;
        dir_d = dir_q;
        if (c_q == CW'(N_LED)) begin
            c_d   = CW'(N_LED - 1);
            dir_d = 1'b0;
        end else if (c_q == CW'(1)) begin
            c_d   = CW'(2);
            dir_d = 1'b1;
        end else if (dir_q) begin
            c_d = c_q + CW'(1);
        end else begin
            c_d = c_q - CW'(1);
        end
    end

`ifdef LED_WAVE_HINT_EN
    assign hint = (c_q < target_q) ? {C_U, C_P} : {C_d, C_n};
`else
    assign hint = {C_BLANK, C_BLANK};
`endif

    always_comb begin
        led_d = wave;
        seg_d = SEG_BLANK;
        case (state_q)
            S_IDLE: led_d = '0;
            S_RUN:  seg_d = {1'b0, tries_q, C_BLANK, tgt_dec};
            S_SHOW: seg_d = {c_dec, hint};
            S_WIN:  seg_d = {C_g, C_o, C_o, C_d};
            S_LOSE: seg_d = {C_n, C_o, tgt_dec};
            default: begin
                led_d = '0;
                seg_d = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            c_q        <= CW'(1);
            dir_q      <= 1'b1;
            target_q   <= CW'(1);
            tries_q    <= 4'(MAX_TRIES);
            tick_q     <= '0;
            btn_prev_q <= 1'b0;
            led_q      <= '0;
            seg_q      <= SEG_BLANK;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            btn_prev_q <= btn_go_stop;
            if (!active) begin
                state_q <= S_IDLE;
                tries_q <= 4'(MAX_TRIES);
                tick_q  <= '0;
                led_q   <= '0;
                seg_q   <= SEG_BLANK;
                win_q   <= 1'b0;
                lose_q  <= 1'b0;
            end else begin
                led_q  <= led_d;
                seg_q  <= seg_d;
                win_q  <= (state_q == S_WIN);
                lose_q <= (state_q == S_LOSE);
                tick_q <= '0;
                case (state_q)
                    S_IDLE: begin
                        state_q  <= S_RUN;
                        target_q <= target_d;
                        c_q      <= CW'(1);
                        dir_q    <= 1'b1;
                        tries_q  <= 4'(MAX_TRIES);
                    end
                    S_RUN: begin
                        // A stop in the same cycle as a tick freezes c
                        if (btn_edge) begin
                            state_q <= S_SHOW;
                            tries_q <= tries_q - 4'd1;
                        end else begin
                            tick_q <= tick_hit ? '0 : tick_q + TW'(1);
                            if (tick_hit) begin
                                c_q   <= c_d;
                                dir_q <= dir_d;
                            end
                        end
                    end
                    S_SHOW: begin
                        if (c_q == target_q)       state_q <= S_WIN;
                        else if (tries_q == 4'd0)  state_q <= S_LOSE;
                        else if (btn_edge)         state_q <= S_RUN;
                    end
                    S_WIN, S_LOSE: begin
                        if (btn_edge) begin
                            state_q <= S_IDLE;
                            tries_q <= 4'(MAX_TRIES);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_wave_guess.sv
// Directed bench for led_wave_guess at N_LED=8, TICK_CYCLES=4, MAX_TRIES=3.
module tb_led_wave_guess;

    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic        btn_go_stop;
    logic [7:0]  led;
    logic [19:0] seg_data;
    logic [3:0]  tries_left;
    logic        win;
    logic        lose;

    int n_chk  = 0;
    int n_fail = 0;

    led_wave_guess #(
        .N_LED       (8),
        .TICK_CYCLES (4),
        .MAX_TRIES   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .btn_go_stop (btn_go_stop),
        .led         (led),
        .seg_data    (seg_data),
        .tries_left  (tries_left),
        .win         (win),
        .lose        (lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          wait_n;
        logic [7:0]  exp_led;
        logic [19:0] exp_seg;
        logic [3:0]  exp_tries;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [19:0] s4(input int a, input int b, input int c, input int d);
        return {5'(a), 5'(b), 5'(c), 5'(d)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        active      = 1'b1;
        btn_go_stop = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    logic [19:0] exp_hint_seg;

    initial begin
        // Walk of the wave with the button idle, target 8 from seed 0xACE1
        vecs[0] = '{2,  8'h80, s4(3, 31, 0, 8), 4'd3};
        vecs[1] = '{4,  8'hC0, s4(3, 31, 0, 8), 4'd3};
        vecs[2] = '{24, 8'hFF, s4(3, 31, 0, 8), 4'd3};
        vecs[3] = '{4,  8'hFE, s4(3, 31, 0, 8), 4'd3};
        vecs[4] = '{24, 8'h80, s4(3, 31, 0, 8), 4'd3};
        vecs[5] = '{4,  8'hC0, s4(3, 31, 0, 8), 4'd3};

`ifdef LED_WAVE_HINT_EN
        exp_hint_seg = s4(0, 3, 15, 16);
`else
        exp_hint_seg = s4(0, 3, 31, 31);
`endif

        // Reset state
        do_reset();
        chk("rst_led",   32'(led),        32'h0);
        chk("rst_seg",   32'(seg_data),   32'hFFFFF);
        chk("rst_tries", 32'(tries_left), 32'd3);
        chk("rst_win",   32'(win),        32'd0);
        chk("rst_lose",  32'(lose),       32'd0);

        for (int i = 0; i < 6; i++) begin
            cyc(vecs[i].wait_n);
            chk($sformatf("wave_led[%0d]", i),   32'(led),        32'(vecs[i].exp_led));
            chk($sformatf("wave_seg[%0d]", i),   32'(seg_data),   32'(vecs[i].exp_seg));
            chk($sformatf("wave_tries[%0d]", i), 32'(tries_left), 32'(vecs[i].exp_tries));
        end

        // Stop at c=8 -> SHOW -> WIN
        do_reset();
        cyc(29);
        btn_go_stop = 1'b1;
        cyc(1);
        chk("win_tries", 32'(tries_left), 32'd2);
        cyc(1);
        chk("win_lag", 32'(win), 32'd0);
        cyc(1);
        chk("win_flag", 32'(win), 32'd1);
        chk("win_seg",  32'(seg_data), 32'(s4(9, 17, 17, 19)));
        btn_go_stop = 1'b0;

        // Three stops at c=3 -> LOSE, with hint display in SHOW
        do_reset();
        cyc(9);
        btn_go_stop = 1'b1;
        cyc(1);
        chk("lose_tries2", 32'(tries_left), 32'd2);
        btn_go_stop = 1'b0;
        cyc(1);
        chk("show_hint", 32'(seg_data), 32'(exp_hint_seg));
        btn_go_stop = 1'b1;
        cyc(1);
        btn_go_stop = 1'b0;
        cyc(1);
        btn_go_stop = 1'b1;
        cyc(1);
        chk("lose_tries1", 32'(tries_left), 32'd1);
        btn_go_stop = 1'b0;
        cyc(1);
        btn_go_stop = 1'b1;
        cyc(1);
        btn_go_stop = 1'b0;
        cyc(1);
        btn_go_stop = 1'b1;
        cyc(1);
        chk("lose_tries0", 32'(tries_left), 32'd0);
        btn_go_stop = 1'b0;
        cyc(1);
        chk("lose_lag", 32'(lose), 32'd0);
        cyc(1);
        chk("lose_flag", 32'(lose), 32'd1);
        chk("lose_seg",  32'(seg_data), 32'(s4(20, 17, 0, 8)));

        // Drop active mid-RUN, then a held button gives a single stop
        do_reset();
        cyc(3);
        btn_go_stop = 1'b1;
        cyc(1);
        btn_go_stop = 1'b0;
        cyc(1);
        btn_go_stop = 1'b1;
        cyc(1);
        btn_go_stop = 1'b0;
        cyc(2);
        active = 1'b0;
        cyc(1);
        chk("drop_led",   32'(led),        32'h0);
        chk("drop_seg",   32'(seg_data),   32'hFFFFF);
        chk("drop_tries", 32'(tries_left), 32'd3);
        active = 1'b1;
        cyc(2);
        btn_go_stop = 1'b1;
        cyc(1);
        chk("hold_first", 32'(tries_left), 32'd2);
        cyc(6);
        chk("hold_single", 32'(tries_left), 32'd2);
        btn_go_stop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
